// File: rtl/mul_div_unit.sv
// mul_div_unit: EX-stage multiply/divide unit holding the HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result at the accept edge into a shadow
// pair. HI/LO are then written after a fixed busy period, so the pipeline
// sees the same latency that an iterative unit would have.
// Optional feature macro: MDU_MADD_EN adds MADD (op 7) and MSUB (op 8).
// These accumulate a signed product into {hi,lo}.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic        kill,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt, next_cnt;
    logic        load_shadow, commit;
    logic [31:0] res_hi, res_lo;
    logic        res_valid;

    logic        accept, is_mul, is_div, is_long;
    logic [63:0] prod_s, prod_u, calc;
    logic [31:0] abs_a, abs_b, div_b_u, div_b_s;
    logic [31:0] quo_u, rem_u, quo_mag, rem_mag, quo_s, rem_s;

    assign busy   = (state == RUN);
    assign accept = start && !kill && !busy;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU)
`ifdef MDU_MADD_EN
                    || (op == OP_MADD) || (op == OP_MSUB)
`endif
                    ;
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign is_long = is_mul || is_div;

    // Products: the signed one sign-extends both operands to 64 bits, so the
    // low 64 bits of the product are the two's-complement result.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Division uses magnitudes, which makes 0x80000000 / -1 wrap cleanly.
    // The divisor is forced to 1 when B is zero. That result is discarded.
    assign abs_a   = A[31] ? (~A + 32'd1) : A;
    assign abs_b   = B[31] ? (~B + 32'd1) : B;
    assign div_b_u = (B == 32'd0) ? 32'd1 : B;
    assign div_b_s = (B == 32'd0) ? 32'd1 : abs_b;
    assign quo_u   = A / div_b_u;
    assign rem_u   = A % div_b_u;
    assign quo_mag = abs_a / div_b_s;
    assign rem_mag = abs_a % div_b_s;
    assign quo_s   = (A[31] ^ B[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s   = A[31] ? (~rem_mag + 32'd1) : rem_mag;

    // Select the 64-bit {hi,lo} result of the operation being accepted.
    always_comb begin
        calc = 64'd0;
        case (op)
            OP_MULT:  calc = prod_s;
            OP_MULTU: calc = prod_u;
            OP_DIV:   calc = {rem_s, quo_s};
            OP_DIVU:  calc = {rem_u, quo_u};
`ifdef MDU_MADD_EN
            OP_MADD:  calc = {hi, lo} + prod_s;
            OP_MSUB:  calc = {hi, lo} - prod_s;
`endif
            default:  calc = 64'd0;
        endcase
    end

    // State register and busy countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next state: load the countdown on accept; commit when it reaches zero.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        load_shadow = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_long) begin
                    next_state  = RUN;
                    next_cnt    = is_div ? DIV_LOAD : MULT_LOAD;
                    load_shadow = 1'b1;
                end
            end
            RUN: begin
                if (cnt == 4'd0) begin
                    next_state = IDLE;
                    commit     = 1'b1;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shadow result is captured at accept. A divide by zero marks it invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_hi    <= 32'd0;
            res_lo    <= 32'd0;
            res_valid <= 1'b0;
        end else if (load_shadow) begin
            res_hi    <= calc[63:32];
            res_lo    <= calc[31:0];
            res_valid <= !(is_div && (B == 32'd0));
        end
    end

    // HI/LO: a completed operation writes both; MTHI/MTLO write one at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            if (res_valid) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if (accept && (op == OP_MTHI)) begin
            hi <= A;
        end else if (accept && (op == OP_MTLO)) begin
            lo <= A;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed testbench for mul_div_unit.
// Vectors carry hand-computed HI/LO values and busy lengths.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  op;
    logic        start, kill;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int cycles;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op),
        .start(start), .kill(kill), .busy(busy), .hi(hi), .lo(lo)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives one op for one cycle and returns at the next negedge.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic k);
        op = o; A = a; B = b; kill = k; start = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0; op = 4'd0;
    endtask

    // Counts negedges seen with busy high, bounded so that a stuck busy cannot hang.
    task automatic waitIdle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; A = 0; B = 0; op = 0; start = 0; kill = 0;
        @(negedge clk); @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // MULT -1 * 2
        applyStimulus(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        checkOutput("mult_busy1", {31'd0, busy}, 32'd1);
        checkOutput("mult_hi_during", hi, 32'd0);
        checkOutput("mult_lo_during", lo, 32'd0);
        waitIdle(cycles);
        checkOutput("mult_cycles", 32'(cycles), 32'd5);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFE);

        // MULTU 0xFFFFFFFF * 2
        applyStimulus(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
        waitIdle(cycles);
        checkOutput("multu_cycles", 32'(cycles), 32'd5);
        checkOutput("multu_hi", hi, 32'd1);
        checkOutput("multu_lo", lo, 32'hFFFFFFFE);

        // MULT 0x80000000 * 0x80000000 = 2^62
        applyStimulus(4'd1, 32'h80000000, 32'h80000000, 1'b0);
        waitIdle(cycles);
        checkOutput("mult_min_hi", hi, 32'h40000000);
        checkOutput("mult_min_lo", lo, 32'd0);

        // DIV -7 / 2
        applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        waitIdle(cycles);
        checkOutput("div_cycles", 32'(cycles), 32'd10);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);

        // DIVU 7 / 2
        applyStimulus(4'd4, 32'd7, 32'd2, 1'b0);
        waitIdle(cycles);
        checkOutput("divu_cycles", 32'(cycles), 32'd10);
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);

        // DIV overflow 0x80000000 / -1
        applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        waitIdle(cycles);
        checkOutput("divovf_lo", lo, 32'h80000000);
        checkOutput("divovf_hi", hi, 32'd0);

        // MTHI / MTLO
        applyStimulus(4'd5, 32'h1234, 32'd0, 1'b0);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        checkOutput("mthi_hi", hi, 32'h1234);
        applyStimulus(4'd6, 32'h5678, 32'd0, 1'b0);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
        checkOutput("mtlo_lo", lo, 32'h5678);
        checkOutput("mtlo_hi", hi, 32'h1234);

        // DIV by zero keeps HI/LO
        applyStimulus(4'd3, 32'd99, 32'd0, 1'b0);
        waitIdle(cycles);
        checkOutput("div0_cycles", 32'(cycles), 32'd10);
        checkOutput("div0_hi", hi, 32'h1234);
        checkOutput("div0_lo", lo, 32'h5678);

        // MULT with kill is ignored
        applyStimulus(4'd1, 32'd3, 32'd4, 1'b1);
        checkOutput("kill_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("kill_hi", hi, 32'h1234);
        checkOutput("kill_lo", lo, 32'h5678);

        // DIVU while busy is ignored
        applyStimulus(4'd1, 32'd3, 32'd4, 1'b0);
        applyStimulus(4'd4, 32'd100, 32'd7, 1'b0);
        waitIdle(cycles);
        checkOutput("busyign_cycles", 32'(cycles), 32'd4);
        checkOutput("busyign_hi", hi, 32'd0);
        checkOutput("busyign_lo", lo, 32'd12);
        @(negedge clk);
        checkOutput("busyign_nolate", {31'd0, busy}, 32'd0);

`ifdef MDU_MADD_EN
        applyStimulus(4'd5, 32'd0, 32'd0, 1'b0);
        applyStimulus(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
        applyStimulus(4'd7, 32'd1, 32'd1, 1'b0);
        waitIdle(cycles);
        checkOutput("madd_cycles", 32'(cycles), 32'd5);
        checkOutput("madd_hi", hi, 32'd1);
        checkOutput("madd_lo", lo, 32'd0);
        applyStimulus(4'd8, 32'd1, 32'd1, 1'b0);
        waitIdle(cycles);
        checkOutput("msub_hi", hi, 32'd0);
        checkOutput("msub_lo", lo, 32'hFFFFFFFF);
`else
        // Without the accumulate feature, op 7 acts as NONE.
        applyStimulus(4'd7, 32'd1, 32'd1, 1'b0);
        checkOutput("op7_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("op7_hi", hi, 32'd0);
        checkOutput("op7_lo", lo, 32'd12);
`endif

        // Back-to-back: the second op is accepted in the cycle busy drops
        applyStimulus(4'd1, 32'd2, 32'd3, 1'b0);
        waitIdle(cycles);
        applyStimulus(4'd2, 32'd5, 32'd5, 1'b0);
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        checkOutput("b2b_first_lo", lo, 32'd6);
        waitIdle(cycles);
        checkOutput("b2b_cycles", 32'(cycles), 32'd5);
        checkOutput("b2b_lo", lo, 32'd25);
        checkOutput("b2b_hi", hi, 32'd0);

        // Reset during RUN aborts the op; no late write afterwards
        applyStimulus(4'd3, 32'd100, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rstrun_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstrun_hi", hi, 32'd0);
        checkOutput("rstrun_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        checkOutput("rstrun_late_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstrun_late_hi", hi, 32'd0);
        checkOutput("rstrun_late_lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
